rom_wave_arb: RTL and testbench

Two-port scheduler sharing one synchronous waveform ROM (315-entry sine table, 1-cycle registered read) between two sample consumers in the Kalman test path, e.g. a noisy-signal generator and a reference channel. Each port has its own wrapping phase counter, so the ports walk the same table at independent rates and offsets. A round-robin arbiter grants at most one read per clock. Data returns per port with a fixed 2-cycle latency.

---
 rtl/rom_wave_arb_if.sv | 29 ++
 rtl/rom_wave_arb.sv | 112 +++++++++++
 tb/tb_rom_wave_arb.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/rom_wave_arb_if.sv
// Bundle of the request/ack, sample and ROM-side signals of rom_wave_arb.
// The slave modport is the scheduler side. The master modport is the side that
// drives the requests and the ROM data.
interface rom_wave_arb_if #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 9
);
  logic              req0;
  logic              req1;
  logic              ack0;
  logic              ack1;
  logic              clr;
  logic [DATA_W-1:0] dout0;
  logic              dvalid0;
  logic [DATA_W-1:0] dout1;
  logic              dvalid1;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_q;

  modport slave (
    input  req0, req1, clr, rom_q,
    output ack0, ack1, dout0, dvalid0, dout1, dvalid1, rom_addr
  );

  modport master (
    output req0, req1, clr, rom_q,
    input  ack0, ack1, dout0, dvalid0, dout1, dvalid1, rom_addr
  );
endinterface

// File: rtl/rom_wave_arb.sv
// Two-port scheduler for one synchronous waveform ROM with a 1-cycle registered read.
// Each port owns a phase counter that wraps after LAST_ADDR. At most one read is
// granted per clock. Samples come back per port 2 clocks after the accept edge.
// Optional macro ROM_WAVE_ARB_PRIO_EN: port 0 gets strict priority instead of
// round-robin arbitration.
module rom_wave_arb #(
  parameter int unsigned ADDR_W    = 9,
  parameter int unsigned DATA_W    = 9,
  parameter int unsigned LAST_ADDR = 314,
  parameter int unsigned PHASE1    = 0
) (
  input logic           clk_50M,
  input logic           Rst_n,
  rom_wave_arb_if.slave bus
);

  localparam logic [ADDR_W-1:0] LastAddr  = ADDR_W'(LAST_ADDR);
  localparam logic [ADDR_W-1:0] Ph1Init   = ADDR_W'(PHASE1);
  localparam logic [ADDR_W-1:0] AddrOne   = ADDR_W'(1);

  logic              ack0;
  logic              ack1;
  logic [ADDR_W-1:0] ph0_q, ph0_d;
  logic [ADDR_W-1:0] ph1_q, ph1_d;
  logic [ADDR_W-1:0] rom_addr_q;
  logic              tag1_vld_q, tag1_port_q;
  logic              tag2_vld_q, tag2_port_q;
  logic [DATA_W-1:0] dout0_q, dout1_q;
  logic              dvalid0_q, dvalid1_q;

`ifdef ROM_WAVE_ARB_PRIO_EN
  // Strict priority: port 0 always wins and no history is kept.
  assign ack0 = bus.req0;
  assign ack1 = bus.req1 & ~bus.req0;
`else
  typedef enum logic {LastP0, LastP1} last_e;
  last_e last_q;

  // Round-robin: on a conflict the port that was not served last wins.
  assign ack0 = bus.req0 & (~bus.req1 | (last_q == LastP1));
  assign ack1 = bus.req1 & (~bus.req0 | (last_q == LastP0));

  // Remember the most recently served port. It resets to port 1 so that port 0
  // wins the first conflict.
  always_ff @(posedge clk_50M or negedge Rst_n) begin
    if (!Rst_n) begin
      last_q <= LastP1;
    end else if (ack1) begin
      last_q <= LastP1;
    end else if (ack0) begin
      last_q <= LastP0;
    end
  end
`endif

  // Phase counters advance on their own ack. clr reloads both counters and
  // overrides the increment.
  always_comb begin
    ph0_d = ph0_q;
    ph1_d = ph1_q;
    if (ack0) ph0_d = (ph0_q == LastAddr) ? '0 : ph0_q + AddrOne;
    if (ack1) ph1_d = (ph1_q == LastAddr) ? '0 : ph1_q + AddrOne;
    if (bus.clr) begin
      ph0_d = '0;
      ph1_d = Ph1Init;
    end
  end

  // Register the ROM address, carry the grant tag through two stages, and
  // capture the ROM data into the owning port's output.
  always_ff @(posedge clk_50M or negedge Rst_n) begin
    if (!Rst_n) begin
      ph0_q       <= '0;
      ph1_q       <= Ph1Init;
      rom_addr_q  <= '0;
      tag1_vld_q  <= 1'b0;
      tag1_port_q <= 1'b0;
      tag2_vld_q  <= 1'b0;
      tag2_port_q <= 1'b0;
      dout0_q     <= '0;
      dout1_q     <= '0;
      dvalid0_q   <= 1'b0;
      dvalid1_q   <= 1'b0;
    end else begin
      ph0_q <= ph0_d;
      ph1_q <= ph1_d;
      // The address uses the pre-clear phase of the granted port.
      if (ack0) begin
        rom_addr_q <= ph0_q;
      end else if (ack1) begin
        rom_addr_q <= ph1_q;
      end
      tag1_vld_q  <= ack0 | ack1;
      tag1_port_q <= ack1;
      tag2_vld_q  <= tag1_vld_q;
      tag2_port_q <= tag1_port_q;
      dvalid0_q   <= tag2_vld_q & ~tag2_port_q;
      dvalid1_q   <= tag2_vld_q & tag2_port_q;
      if (tag2_vld_q && !tag2_port_q) dout0_q <= bus.rom_q;
      if (tag2_vld_q && tag2_port_q)  dout1_q <= bus.rom_q;
    end
  end

  assign bus.ack0     = ack0;
  assign bus.ack1     = ack1;
  assign bus.rom_addr = rom_addr_q;
  assign bus.dout0    = dout0_q;
  assign bus.dout1    = dout1_q;
  assign bus.dvalid0  = dvalid0_q;
  assign bus.dvalid1  = dvalid1_q;

endmodule

// File: tb/tb_rom_wave_arb.sv
// Scoreboard bench for rom_wave_arb. A reference model predicts the grants and
// pushes the expected samples with their due cycle into per-port queues. A
// separate monitor pops those entries when the DUT presents dvalid.
module tb_rom_wave_arb;
  localparam int unsigned AW    = 9;
  localparam int unsigned DW    = 9;
  localparam int unsigned Last  = 314;
  localparam int unsigned Ph1   = 100;
  localparam int          Depth = 315;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;

  rom_wave_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  rom_wave_arb #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .LAST_ADDR(Last),
    .PHASE1   (Ph1)
  ) dut (
    .clk_50M(clk),
    .Rst_n  (rst_n),
    .bus    (bus)
  );

  logic [DW-1:0] rom [Depth];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous ROM with a 1-cycle registered read.
  always @(posedge clk) begin
    if (int'(bus.rom_addr) < Depth) bus.rom_q <= rom[bus.rom_addr];
    else                            bus.rom_q <= '0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int data;
    int due;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  // Reference model state. The phases wrap modulo the table length.
  int m_ph0  = 0;
  int m_ph1  = Ph1;
  int m_last = 1;
  int m_addr = 0;

  // Model process: predicts the grants, checks ack and rom_addr, and queues the
  // expected samples.
  always @(negedge clk) begin
    bit e0, e1;
    if (!rst_n) begin
      m_ph0  = 0;
      m_ph1  = Ph1;
      m_last = 1;
      m_addr = 0;
      chk("rst_rom_addr", bus.rom_addr, 0);
    end else begin
      chk("rom_addr", bus.rom_addr, m_addr);
`ifdef ROM_WAVE_ARB_PRIO_EN
      e0 = bus.req0;
      e1 = bus.req1 && !bus.req0;
`else
      if (bus.req0 && bus.req1) begin
        e0 = (m_last == 1);
        e1 = !e0;
      end else begin
        e0 = bus.req0;
        e1 = bus.req1;
      end
`endif
      chk("ack0", bus.ack0, e0);
      chk("ack1", bus.ack1, e1);
      if (e0) begin
        q0.push_back('{data: int'(rom[m_ph0]), due: cyc + 3});
        m_addr = m_ph0;
        m_ph0  = (m_ph0 + 1) % Depth;
        m_last = 0;
      end
      if (e1) begin
        q1.push_back('{data: int'(rom[m_ph1]), due: cyc + 3});
        m_addr = m_ph1;
        m_ph1  = (m_ph1 + 1) % Depth;
        m_last = 1;
      end
      if (bus.clr) begin
        m_ph0 = 0;
        m_ph1 = Ph1;
      end
    end
  end

  int exp_dout0 = 0;
  int exp_dout1 = 0;

  // Monitor process: pops the expected samples when they fall due, and checks
  // dvalid and the held output values every cycle.
  always @(negedge clk) begin
    bit   v0, v1;
    exp_t e;
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      exp_dout0 = 0;
      exp_dout1 = 0;
      chk("rst_dvalid0", bus.dvalid0, 0);
      chk("rst_dvalid1", bus.dvalid1, 0);
      chk("rst_dout0", bus.dout0, 0);
      chk("rst_dout1", bus.dout1, 0);
    end else begin
      v0 = (q0.size() > 0) && (q0[0].due == cyc);
      v1 = (q1.size() > 0) && (q1[0].due == cyc);
      chk("dvalid0", bus.dvalid0, v0);
      chk("dvalid1", bus.dvalid1, v1);
      if (v0) begin
        e = q0.pop_front();
        exp_dout0 = e.data;
      end
      if (v1) begin
        e = q1.pop_front();
        exp_dout1 = e.data;
      end
      chk("dout0", bus.dout0, exp_dout0);
      chk("dout1", bus.dout1, exp_dout1);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < Depth; i++) rom[i] = DW'($urandom_range(0, 511));
    rst_n    = 1'b0;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.clr  = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(2);

    // Port 0 streaming through a full table wrap.
    bus.req0 = 1'b1;
    step(320);
    bus.req0 = 1'b0;
    step(5);

    // Clear, take 10 reads, then clear together with an accepted read.
    bus.clr = 1'b1;
    step(1);
    bus.clr  = 1'b0;
    bus.req0 = 1'b1;
    step(10);
    bus.clr = 1'b1;
    step(1);
    bus.clr = 1'b0;
    step(1);
    bus.req0 = 1'b0;
    bus.req1 = 1'b1;
    step(1);
    bus.req1 = 1'b0;
    step(5);

    // Both ports requesting from a fresh reset, then port 0 drops out.
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    step(40);
    bus.req0 = 1'b0;
    step(3);
    bus.req1 = 1'b0;
    step(5);

    // Reset while a read is still in flight.
    bus.req0 = 1'b1;
    step(1);
    bus.req0 = 1'b0;
    step(1);
    rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(5);
    bus.req0 = 1'b1;
    step(1);
    bus.req0 = 1'b0;
    step(5);

    // Idle period with no requests.
    step(50);

    // Random requests and clears.
    for (int i = 0; i < 400; i++) begin
      bus.req0 = 1'($urandom_range(0, 1));
      bus.req1 = 1'($urandom_range(0, 1));
      bus.clr  = ($urandom_range(0, 15) == 0);
      step(1);
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.clr  = 1'b0;
    step(6);

    chk("drain_q0", q0.size(), 0);
    chk("drain_q1", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
